ex_wb_stage: RTL and testbench
==============================

Name: ex_wb_stage

Overview:
- Consumer end of the ID/EX pipeline register in the 4-stage 8-bit core.
- Executes the ALU op on the ID/EX operands and holds the result in an EX/WB register.
- Drives the single-write-port register file, serialising the two destination writes (result -> Reg, Data3 -> Reg2) across two cycles.
- Stalls the upstream pipeline while the second write is pending.

Parameters:
- DATA_W, 8, operand/result width.
- REG_W, 3, register-number width.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_ex_regwrite  in  1  instruction writes registers (0 = bubble).
- id_ex_aluop  in  1  0 = Data1+Data2, 1 = Data1-Data2.
- id_ex_data1  in  DATA_W  ALU operand A.
- id_ex_data2  in  DATA_W  ALU operand B.
- id_ex_data3  in  DATA_W  value for second destination.
- id_ex_reg  in  REG_W  first destination (ALU result).
- id_ex_reg2  in  REG_W  second destination (data3).
- flush  in  1  replace the instruction being captured this edge with a bubble.
- stall  out  1  upstream must hold ID/EX contents this cycle.
- wb_we  out  1  register-file write enable.
- wb_addr  out  REG_W  register-file write address.
- wb_data  out  DATA_W  register-file write data.
- flag_zero  out  1  last executed ALU result == 0.
- flag_carry  out  1  carry out (add) / borrow (sub) of last ALU op.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. The clock port is named clk and the reset port rst.
- Reset, asynchronous on rst=1:
  - state = IDLE; EX/WB register cleared.
  - All outputs 0: stall, wb_we, wb_addr, wb_data, flag_zero, flag_carry.
  - A write in progress, including a pending WB2, is discarded.
- States: IDLE (no valid instruction held), WB1 (first write presented), WB2 (second write presented).
- Capture enable = !stall. On each rising edge with capture enabled, the EX/WB register loads the ID/EX inputs and the ALU result.
  - Result: A+B or A-B, both modulo 2^DATA_W.
  - carry: bit DATA_W of the (DATA_W+1)-bit sum. For sub, borrow = (A < B), unsigned.
- Bubble/flush capture: if id_ex_regwrite=0 or flush=1 at capture, the instruction is a bubble.
  - Next state IDLE; flags are not updated.
- Valid capture: next state WB1; flag_zero and flag_carry update on that edge.
- dual = held regwrite AND (held reg2 != held reg).
  - If reg2 == reg, only the result write occurs and data3 is dropped.
- WB1 outputs: wb_we=1, wb_addr=held reg, wb_data=held result.
  - stall = dual, combinational from state registers only; no combinational path from the id_ex_* inputs.
  - dual=1: no capture this edge; next state WB2.
  - dual=0: capture at the edge as above.
- WB2 outputs: wb_we=1, wb_addr=held reg2, wb_data=held data3, stall=0.
  - Capture at the edge; next state is WB1 or IDLE according to the captured instruction.
- IDLE outputs: wb_we=0, stall=0; wb_addr/wb_data hold their last values.
- Latency:
  - Instruction sampled at edge N: first write visible in cycle N+1.
  - Second write visible in cycle N+2.
  - Throughput: 1 instr/cycle single-dest, 1 per 2 cycles dual-dest.
- flush while stall=1: ignored, since nothing is captured. Upstream re-presents the instruction and flush applies at the next capturing edge if still asserted.
- Back-to-back single-dest instructions: state stays WB1 with wb_we continuously 1.

Test Plan:
- Reset: rst pulse mid-cycle while in WB2 -> all outputs 0 immediately (asynchronous); after release, wb_we stays 0 until the next valid capture.
- Single-dest add: regwrite=1, aluop=0, d1=0x7F, d2=0x01, reg=2, reg2=2 -> next cycle wb_we=1, addr=2, data=0x80, stall=0, zero=0, carry=0; following cycle IDLE.
- Dual write with stall: aluop=1, d1=0x05, d2=0x05, d3=0xA5, reg=1, reg2=4, held 2 cycles by upstream:
  - Cycle 1: addr=1, data=0x00, stall=1, zero=1, carry=0.
  - Cycle 2: addr=4, data=0xA5, stall=0.
  - Instruction is not captured twice.
- Borrow/overflow: add 0xFF+0x01 -> data=0x00, zero=1, carry=1. Then sub 0x00-0x01 -> data=0xFF, carry=1, zero=0.
- Flush/bubble: valid instruction with flush=1 -> wb_we=0 next cycle, flags unchanged. regwrite=0 -> same.
- Back-to-back: three single-dest adds on consecutive cycles -> wb_we=1 for 3 consecutive cycles with addresses/data in order, stall never asserted.

Source files
------------

// File: rtl/ex_wb_stage.sv
// EX/WB stage of the 4-stage 8-bit core: executes the ALU op on the ID/EX
// operands, holds the result, and drives the single-port register file,
// splitting a dual-destination instruction into two consecutive writes.
module ex_wb_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ex_regwrite,
  input  logic              id_ex_aluop,
  input  logic [DATA_W-1:0] id_ex_data1,
  input  logic [DATA_W-1:0] id_ex_data2,
  input  logic [DATA_W-1:0] id_ex_data3,
  input  logic [REG_W-1:0]  id_ex_reg,
  input  logic [REG_W-1:0]  id_ex_reg2,
  input  logic              flush,
  output logic              stall,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_zero,
  output logic              flag_carry
);

  typedef enum logic [1:0] {StIdle, StWb1, StWb2} state_e;

  state_e              state_q, state_d;
  logic                dual_q, dual_d;
  logic [REG_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [REG_W-1:0]    reg2_q, reg2_d;
  logic [DATA_W-1:0]   data3_q, data3_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic [DATA_W:0]     alu_full;
  logic                capture;
  logic                valid_in;

  // ALU: the extra top bit is carry for add and borrow for sub.
  always_comb begin
    alu_full = '0;
    if (id_ex_aluop) begin
      alu_full = {1'b0, id_ex_data1} - {1'b0, id_ex_data2};
    end else begin
      alu_full = {1'b0, id_ex_data1} + {1'b0, id_ex_data2};
    end
  end

  // Outputs come from state registers only, so stall has no input path.
  always_comb begin
    stall      = (state_q == StWb1) && dual_q;
    wb_we      = (state_q != StIdle);
    wb_addr    = addr_q;
    wb_data    = data_q;
    flag_zero  = zero_q;
    flag_carry = carry_q;
  end

  // Next-state: capture a new instruction unless the second write is pending.
  always_comb begin
    capture  = !stall;
    valid_in = id_ex_regwrite && !flush;
    state_d  = state_q;
    dual_d   = dual_q;
    addr_d   = addr_q;
    data_d   = data_q;
    reg2_d   = reg2_q;
    data3_d  = data3_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    if (!capture) begin
      // Present the held second destination; nothing new is taken in.
      state_d = StWb2;
      dual_d  = 1'b0;
      addr_d  = reg2_q;
      data_d  = data3_q;
    end else if (valid_in) begin
      state_d = StWb1;
      dual_d  = (id_ex_reg2 != id_ex_reg);
      addr_d  = id_ex_reg;
      data_d  = alu_full[DATA_W-1:0];
      reg2_d  = id_ex_reg2;
      data3_d = id_ex_data3;
      zero_d  = (alu_full[DATA_W-1:0] == '0);
      carry_d = alu_full[DATA_W];
    end else begin
      // Bubble: address/data keep their last values, flags untouched.
      state_d = StIdle;
      dual_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dual_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      reg2_q  <= '0;
      data3_q <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dual_q  <= dual_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      reg2_q  <= reg2_d;
      data3_q <= data3_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed vector table, reset-in-WB2 sequence, and
// randomized traffic checked against a write-queue reference model.
module tb_ex_wb_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_ex_regwrite, id_ex_aluop, flush;
  logic [7:0] id_ex_data1, id_ex_data2, id_ex_data3;
  logic [2:0] id_ex_reg, id_ex_reg2;
  logic       stall, wb_we, flag_zero, flag_carry;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;

  int checks = 0;
  int errors = 0;

  ex_wb_stage #(.DATA_W(8), .REG_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_ex_regwrite (id_ex_regwrite),
    .id_ex_aluop    (id_ex_aluop),
    .id_ex_data1    (id_ex_data1),
    .id_ex_data2    (id_ex_data2),
    .id_ex_data3    (id_ex_data3),
    .id_ex_reg      (id_ex_reg),
    .id_ex_reg2     (id_ex_reg2),
    .flush          (flush),
    .stall          (stall),
    .wb_we          (wb_we),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .flag_zero      (flag_zero),
    .flag_carry     (flag_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw, op, fl;
    logic [7:0] d1, d2, d3;
    logic [2:0] r, r2;
    logic       we, st, z, c;
    logic [2:0] a;
    logic [7:0] d;
  } vec_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  // Reference model: queue of writes still to be presented; head is current.
  wr_t        mq[$];
  logic [2:0] m_addr;
  logic [7:0] m_data;
  logic       m_zero, m_carry;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rw, input logic op, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3,
                       input logic [2:0] r, input logic [2:0] r2, input logic fl);
    id_ex_regwrite = rw;
    id_ex_aluop    = op;
    id_ex_data1    = d1;
    id_ex_data2    = d2;
    id_ex_data3    = d3;
    id_ex_reg      = r;
    id_ex_reg2     = r2;
    flush          = fl;
  endtask

  task automatic model_reset();
    mq.delete();
    m_addr  = 0;
    m_data  = 0;
    m_zero  = 0;
    m_carry = 0;
  endtask

  // Apply one edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit busy;
    int sum, res;
    wr_t w;
    busy = (mq.size() > 1);
    if (mq.size() > 0) void'(mq.pop_front());
    if (!busy && id_ex_regwrite && !flush) begin
      if (id_ex_aluop) sum = int'(id_ex_data1) - int'(id_ex_data2);
      else             sum = int'(id_ex_data1) + int'(id_ex_data2);
      res     = sum & 255;
      m_carry = id_ex_aluop ? (id_ex_data1 < id_ex_data2) : (sum > 255);
      m_zero  = (res == 0);
      w.a = id_ex_reg;  w.d = 8'(res);      mq.push_back(w);
      if (id_ex_reg2 != id_ex_reg) begin
        w.a = id_ex_reg2; w.d = id_ex_data3; mq.push_back(w);
      end
    end
    if (mq.size() > 0) begin
      m_addr = mq[0].a;
      m_data = mq[0].d;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".we"},    int'(wb_we),      int'(mq.size() > 0));
    chk({tag, ".stall"}, int'(stall),      int'(mq.size() > 1));
    chk({tag, ".addr"},  int'(wb_addr),    int'(m_addr));
    chk({tag, ".data"},  int'(wb_data),    int'(m_data));
    chk({tag, ".zero"},  int'(flag_zero),  int'(m_zero));
    chk({tag, ".carry"}, int'(flag_carry), int'(m_carry));
  endtask

  vec_t vt[18];

  initial begin
    // rw op fl  d1     d2     d3     r  r2 | we st z c  a  d
    vt[0]  = '{1,0,0, 8'h7F,8'h01,8'h00, 2,2, 1,0,0,0, 2,8'h80};
    vt[1]  = '{0,0,0, 8'h00,8'h00,8'h00, 0,0, 0,0,0,0, 2,8'h80};
    vt[2]  = '{1,1,0, 8'h05,8'h05,8'hA5, 1,4, 1,1,1,0, 1,8'h00};
    vt[3]  = '{1,1,0, 8'h05,8'h05,8'hA5, 1,4, 1,0,1,0, 4,8'hA5};
    vt[4]  = '{0,0,0, 8'h00,8'h00,8'h00, 0,0, 0,0,1,0, 4,8'hA5};
    vt[5]  = '{1,0,0, 8'hFF,8'h01,8'h00, 3,3, 1,0,1,1, 3,8'h00};
    vt[6]  = '{1,1,0, 8'h00,8'h01,8'h00, 5,5, 1,0,0,1, 5,8'hFF};
    vt[7]  = '{1,0,1, 8'h01,8'h01,8'h00, 6,6, 0,0,0,1, 5,8'hFF};
    vt[8]  = '{0,0,0, 8'h01,8'h01,8'h00, 6,6, 0,0,0,1, 5,8'hFF};
    vt[9]  = '{1,0,0, 8'h10,8'h01,8'h00, 1,1, 1,0,0,0, 1,8'h11};
    vt[10] = '{1,0,0, 8'h20,8'h02,8'h00, 2,2, 1,0,0,0, 2,8'h22};
    vt[11] = '{1,0,0, 8'h30,8'h03,8'h00, 3,3, 1,0,0,0, 3,8'h33};
    vt[12] = '{0,0,0, 8'h00,8'h00,8'h00, 0,0, 0,0,0,0, 3,8'h33};
    vt[13] = '{1,0,0, 8'h01,8'h02,8'h5A, 1,0, 1,1,0,0, 1,8'h03};
    vt[14] = '{1,0,1, 8'h01,8'h02,8'h5A, 1,0, 1,0,0,0, 0,8'h5A};
    vt[15] = '{1,0,0, 8'h01,8'h02,8'h5A, 1,0, 1,1,0,0, 1,8'h03};
    vt[16] = '{0,0,0, 8'h00,8'h00,8'h00, 0,0, 1,0,0,0, 0,8'h5A};
    vt[17] = '{0,0,0, 8'h00,8'h00,8'h00, 0,0, 0,0,0,0, 0,8'h5A};

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("reset.we", int'(wb_we), 0);
    chk("reset.stall", int'(stall), 0);
    chk("reset.addr", int'(wb_addr), 0);
    chk("reset.data", int'(wb_data), 0);
    chk("reset.flags", int'({flag_zero, flag_carry}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: each row is one cycle, checked at the following negedge.
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].rw, vt[i].op, vt[i].d1, vt[i].d2, vt[i].d3, vt[i].r, vt[i].r2, vt[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d.we", i),    int'(wb_we),      int'(vt[i].we));
      chk($sformatf("vec%0d.stall", i), int'(stall),      int'(vt[i].st));
      chk($sformatf("vec%0d.addr", i),  int'(wb_addr),    int'(vt[i].a));
      chk($sformatf("vec%0d.data", i),  int'(wb_data),    int'(vt[i].d));
      chk($sformatf("vec%0d.zero", i),  int'(flag_zero),  int'(vt[i].z));
      chk($sformatf("vec%0d.carry", i), int'(flag_carry), int'(vt[i].c));
    end

    // Asynchronous reset arriving mid-cycle while the second write is shown.
    drive(1, 0, 8'h03, 8'h04, 8'hC3, 2, 6, 0);
    @(negedge clk);
    @(negedge clk);
    chk("wb2.we", int'(wb_we), 1);
    chk("wb2.addr", int'(wb_addr), 6);
    chk("wb2.data", int'(wb_data), 8'hC3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.we", int'(wb_we), 0);
    chk("async_rst.addr", int'(wb_addr), 0);
    chk("async_rst.data", int'(wb_data), 0);
    chk("async_rst.flags", int'({flag_zero, flag_carry, stall}), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.we", int'(wb_we), 0);
    chk("post_rst.addr", int'(wb_addr), 0);
    model_reset();

    // Randomized traffic; upstream holds its inputs while stalled.
    for (int i = 0; i < 400; i++) begin
      if (mq.size() > 1) begin
        flush = 1'($urandom_range(0, 3) == 0);
      end else begin
        drive(1'($urandom_range(0, 4) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 3'($urandom), 3'($urandom),
              1'($urandom_range(0, 7) == 0));
        if ($urandom_range(0, 1) == 0) id_ex_reg2 = id_ex_reg;
        if ($urandom_range(0, 7) == 0) id_ex_data2 = id_ex_data1;
      end
      model_edge();
      @(negedge clk);
      model_check($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
